fifo_uart_tx_amisha: RTL and testbench
======================================

FIFO_UART_TX_AMISHA -- requirements
Module: fifo_uart_tx_amisha

Interface
REQ-001 Parameter DBIT, default 8: data bits per frame.
REQ-002 Parameter SB_TICK, default 16: stop-bit length in oversample ticks (16 = 1 stop bit).
REQ-003 Parameter DVSR, default 163: clock cycles per oversample tick (16x baud).
REQ-004 clk_amisha  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_amisha  input  1  synchronous, active-low reset.
REQ-006 empty_amisha  input  1  FIFO empty flag.
REQ-007 r_data_amisha  input  DBIT  FIFO head word, valid whenever empty_amisha=0 (first-word fall-through).
REQ-008 rd_amisha  output  1  FIFO pop strobe, one cycle per word consumed.
REQ-009 tx_amisha  output  1  serial line, idle high.
REQ-010 tx_busy_amisha  output  1  high while a frame is in progress.
REQ-011 tx_done_tick_amisha  output  1  one-cycle pulse at end of each frame.

Function
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY (macro only), and STOP.
REQ-013 rd_amisha SHALL be combinational: 1 exactly when state=IDLE, empty_amisha=0, and reset_amisha=1.
REQ-014 When rd_amisha=1, the block SHALL latch r_data_amisha into the shift register, clear the baud and tick counters, and enter START on the same edge.
REQ-015 The baud counter SHALL count 0..DVSR-1 outside IDLE; a tick occurs in the cycle it equals DVSR-1.
REQ-016 START SHALL drive tx_amisha=0 for 16 ticks (16*DVSR clocks), then enter DATA.
REQ-017 DATA SHALL drive the shift-register LSB for 16 ticks per bit, LSB first, shifting right after each bit.
REQ-018 After DBIT bits, the FSM SHALL enter PARITY if compiled in, otherwise STOP.
REQ-019 STOP SHALL drive tx_amisha=1 for SB_TICK ticks, then enter IDLE with tx_done_tick_amisha=1 for that one cycle.
REQ-020 A frame without parity SHALL last exactly (16*(1+DBIT)+SB_TICK)*DVSR clocks from the pop edge to the return to IDLE.
REQ-021 IDLE SHALL drive tx_amisha=1; back-to-back frames SHALL be separated by exactly one IDLE cycle, with the pop in that cycle.
REQ-022 tx_busy_amisha SHALL be 1 in every state except IDLE.
REQ-023 empty_amisha and r_data_amisha changes SHALL be ignored outside IDLE; the latched word SHALL not change mid-frame.
REQ-024 Exactly one pop SHALL occur per frame; no pop SHALL occur while empty_amisha=1.

Reset
REQ-025 With reset_amisha=0 at a rising edge: state=IDLE, counters=0, shift register=0, tx_amisha=1, tx_busy_amisha=0, tx_done_tick_amisha=0.
REQ-026 While reset_amisha=0, rd_amisha SHALL be 0.
REQ-027 Reset mid-frame SHALL abort the frame with no done tick; the aborted word is lost, not re-read.

Configuration
REQ-028 With macro UART_TX_PARITY_EN defined, PARITY SHALL drive the even-parity bit (XOR of the DBIT latched bits) for 16 ticks before STOP, and the frame SHALL be 16*DVSR clocks longer.
REQ-029 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Structure
REQ-030 State encodings and the oversample constant 16 SHALL reside in shared package uart_pkg_amisha.
REQ-031 The baud divider SHALL be a sub-module, baud_gen_amisha (parameter DVSR; inputs clk, reset, clear; output tick).
REQ-032 The FSM, shift register, and parity SHALL reside in fifo_uart_tx_amisha; RTL SHALL be 120-400 lines.

Verification (DBIT=8, SB_TICK=16, DVSR=4; bit period 64 clocks)
REQ-033 Reset held 3 cycles with empty_amisha=0 -> rd_amisha=0, tx_amisha=1, tx_busy_amisha=0 throughout.
REQ-034 Single word 0xA5 -> one rd_amisha pulse; line samples at mid-bit = 0,1,0,1,0,0,1,0,1,1; done tick 640 clocks after the pop.
REQ-035 Three words 0x00, 0xFF, 0x3C queued -> three pops 641 clocks apart, in order; empty_amisha held 1 -> no pops, tx_amisha=1.
REQ-036 Reset asserted 200 clocks into a frame -> tx_amisha=1 next edge, no done tick, next frame starts cleanly with the following word.
REQ-037 r_data_amisha changed mid-frame -> transmitted bits still match the word latched at the pop.
REQ-038 UART_TX_PARITY_EN with 0x07 -> parity bit 1, frame 704 clocks; with 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg_amisha.sv
// uart_pkg_amisha: shared state encoding and oversample constant for the UART transmitter.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
package uart_pkg_amisha;

  // Oversample ticks per serial bit (16x baud).
  localparam int OS_TICKS = 16;

  // Transmitter FSM states; PARITY exists only when the parity feature is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/baud_gen_amisha.sv
// baud_gen_amisha: oversample tick divider. Counts 0..DVSR-1 while not cleared and
// asserts tick in the cycle the count equals DVSR-1. reset is synchronous, active-low.
module baud_gen_amisha #(
  parameter int DVSR = 163
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DVSR - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: held at zero while cleared, wraps after the last cycle of a tick period.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST) && !clear;

endmodule

// File: rtl/fifo_uart_tx_amisha.sv
// fifo_uart_tx_amisha: UART transmitter fed from a first-word fall-through FIFO.
// Pops one word per frame, sends start, DBIT data bits LSB first, optional even parity,
// and SB_TICK ticks of stop. Define UART_TX_PARITY_EN to compile in the parity bit.
module fifo_uart_tx_amisha
  import uart_pkg_amisha::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163
) (
  input  logic            clk_amisha,
  input  logic            reset_amisha,
  input  logic            empty_amisha,
  input  logic [DBIT-1:0] r_data_amisha,
  output logic            rd_amisha,
  output logic            tx_amisha,
  output logic            tx_busy_amisha,
  output logic            tx_done_tick_amisha
);

  localparam int S_MAX = (SB_TICK > OS_TICKS) ? SB_TICK : OS_TICKS;
  localparam int SW    = $clog2(S_MAX);
  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] OS_LAST  = SW'(OS_TICKS - 1);
  localparam logic [SW-1:0] SB_LAST  = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] BIT_LAST = NW'(DBIT - 1);

  tx_state_e       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;       // oversample ticks within the current bit
  logic [NW-1:0]   n_q, n_d;       // data bit index
  logic [DBIT-1:0] b_q, b_d;       // shift register holding the word being sent
  logic            tx_q, tx_d;
  logic            done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;   // even parity of the latched word
`endif
  logic            tick;
  logic            baud_clear;

  // The divider is held at zero in IDLE so every frame starts on a fresh tick phase.
  assign baud_clear = (state_q == ST_IDLE);

  baud_gen_amisha #(
    .DVSR(DVSR)
  ) u_baud (
    .clk  (clk_amisha),
    .reset(reset_amisha),
    .clear(baud_clear),
    .tick (tick)
  );

  assign rd_amisha           = (state_q == ST_IDLE) && !empty_amisha && reset_amisha;
  assign tx_busy_amisha      = (state_q != ST_IDLE);
  assign tx_amisha           = tx_q;
  assign tx_done_tick_amisha = done_q;

  // Next-state logic; the line level is derived from the state being entered so tx is registered.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rd_amisha) begin
          state_d = ST_START;
          b_d     = r_data_amisha;
          s_d     = '0;
          n_d     = '0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^r_data_amisha;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          if (s_q == OS_LAST) begin
            s_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (s_q == OS_LAST) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (s_q == OS_LAST) begin
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (s_q == SB_LAST) begin
            s_d     = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight without a done tick.
  always_ff @(posedge clk_amisha) begin
    if (!reset_amisha) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx_amisha.sv
// tb_fifo_uart_tx_amisha: scoreboard bench for fifo_uart_tx_amisha (DBIT=8, SB_TICK=16, DVSR=4).
// Honours UART_TX_PARITY_EN when the design is built with it.
`timescale 1ns/1ps
module tb_fifo_uart_tx_amisha;

  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
  localparam int DVSR    = 4;
  localparam int BITP    = 16 * DVSR;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS   = 11;
`else
  localparam int NBITS   = 10;
`endif
  localparam int FRAME   = (16 * (NBITS - 1) + SB_TICK) * DVSR;

  logic            clk_amisha = 1'b0;
  logic            reset_amisha = 1'b0;
  logic            empty_amisha = 1'b1;
  logic [DBIT-1:0] r_data_amisha = '0;
  logic            rd_amisha;
  logic            tx_amisha;
  logic            tx_busy_amisha;
  logic            tx_done_tick_amisha;

  fifo_uart_tx_amisha #(
    .DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR(DVSR)
  ) dut (
    .clk_amisha         (clk_amisha),
    .reset_amisha       (reset_amisha),
    .empty_amisha       (empty_amisha),
    .r_data_amisha      (r_data_amisha),
    .rd_amisha          (rd_amisha),
    .tx_amisha          (tx_amisha),
    .tx_busy_amisha     (tx_busy_amisha),
    .tx_done_tick_amisha(tx_done_tick_amisha)
  );

  always #5 clk_amisha = ~clk_amisha;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit pop_pend = 1'b0;
  bit mon_active = 1'b0;
  logic [7:0] noise = 8'h00;
  logic [7:0] fifo[$];
  logic [7:0] push_q[$];
  logic [7:0] exp_q[$];
  int pop_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    push_q.push_back(w);
    exp_q.push_back(w);
    $display("[TB] queue word %02h", w);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    bit idle = 1'b0;
    while (!idle && n < budget) begin
      @(negedge clk_amisha);
      n++;
      idle = (exp_q.size() == 0) && (push_q.size() == 0) && (fifo.size() == 0) &&
             !mon_active && !tx_busy_amisha;
    end
    if (!idle) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", tag, n);
    end
    @(posedge clk_amisha);
    #1;
  endtask

  // Cycle counter used to timestamp pops.
  initial forever begin
    @(posedge clk_amisha);
    cyc++;
  end

  // Count done pulses across the whole run, including across aborted frames.
  initial forever begin
    @(negedge clk_amisha);
    if (tx_done_tick_amisha === 1'b1) done_cnt++;
  end

  // Record the pop strobe away from the edge that consumes it.
  initial forever begin
    @(negedge clk_amisha);
    pop_pend = (rd_amisha === 1'b1);
  end

  // First-word fall-through FIFO model driving empty/r_data just after each edge.
  initial forever begin
    @(posedge clk_amisha);
    #1;
    if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
    while (push_q.size() > 0) fifo.push_back(push_q.pop_front());
    empty_amisha  = (fifo.size() == 0);
    r_data_amisha = (fifo.size() != 0) ? fifo[0] : noise;
  end

  // Monitor: on each pop, take the next expected word and check the serial frame it produces.
  initial begin : monitor
    logic [7:0]       w;
    logic [NBITS-1:0] bits;
    bit               skip;
    bit               aborted;
    skip = 1'b0;
    forever begin
      if (!skip) @(negedge clk_amisha);
      skip = 1'b0;
      if (reset_amisha === 1'b1 && rd_amisha === 1'b1) begin
        mon_active = 1'b1;
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pop: got rd=1 expected no pop (cycle %0d)", cyc);
          mon_active = 1'b0;
        end else begin
          w = exp_q.pop_front();
          bits = '1;
          bits[0] = 1'b0;
          for (int i = 0; i < DBIT; i++) bits[1 + i] = w[i];
`ifdef UART_TX_PARITY_EN
          bits[DBIT + 1] = ^w;
`endif
          aborted = 1'b0;
          for (int t = 1; t <= FRAME + 1; t++) begin
            @(negedge clk_amisha);
            if ((t % BITP) == BITP / 2 && (t / BITP) < NBITS) begin
              check($sformatf("word%02h_bit%0d", w, t / BITP), tx_amisha, bits[t / BITP]);
            end
            if (t == FRAME) check($sformatf("word%02h_no_early_done", w), tx_done_tick_amisha, 0);
            if (t == FRAME + 1) begin
              check($sformatf("word%02h_done", w), tx_done_tick_amisha, 1);
              check($sformatf("word%02h_busy_end", w), tx_busy_amisha, 0);
            end
            if (reset_amisha !== 1'b1) begin
              aborted = 1'b1;
              break;
            end
          end
          if (aborted) begin
            @(negedge clk_amisha);
            check($sformatf("word%02h_abort_tx", w), tx_amisha, 1);
            check($sformatf("word%02h_abort_busy", w), tx_busy_amisha, 0);
            check($sformatf("word%02h_abort_done", w), tx_done_tick_amisha, 0);
            $display("[TB] frame %02h aborted by reset", w);
          end else begin
            $display("[TB] frame %02h checked", w);
            skip = 1'b1;
          end
          mon_active = 1'b0;
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin : stim
    int n0;
    int k;

    // Reset held with a word waiting: no pop, line idle, not busy.
    reset_amisha = 1'b0;
    push_word(8'hA5);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_amisha);
      check("reset_rd", rd_amisha, 0);
      check("reset_tx", tx_amisha, 1);
      check("reset_busy", tx_busy_amisha, 0);
      check("reset_done", tx_done_tick_amisha, 0);
    end
    @(posedge clk_amisha);
    #1;
    reset_amisha = 1'b1;

    // Single word 0xA5.
    wait_idle(2000, "single");
    check("single_pops", pop_cyc.size(), 1);

    // Three back-to-back words.
    n0 = pop_cyc.size();
    push_word(8'h00);
    push_word(8'hFF);
    push_word(8'h3C);
    wait_idle(4000, "burst");
    check("burst_pops", pop_cyc.size() - n0, 3);
    if (pop_cyc.size() - n0 == 3) begin
      check("burst_gap1", pop_cyc[n0 + 1] - pop_cyc[n0], FRAME + 1);
      check("burst_gap2", pop_cyc[n0 + 2] - pop_cyc[n0 + 1], FRAME + 1);
    end

    // FIFO empty: no pops, line stays high.
    for (int i = 0; i < 20; i++) begin
      repeat (10) @(negedge clk_amisha);
      check("empty_rd", rd_amisha, 0);
      check("empty_tx", tx_amisha, 1);
      check("empty_busy", tx_busy_amisha, 0);
    end

    // Reset 200 clocks into a frame; the next word must follow cleanly.
    n0 = pop_cyc.size();
    push_word(8'h81);
    push_word(8'h42);
    k = 0;
    while (pop_cyc.size() == n0 && k < 100) begin
      @(negedge clk_amisha);
      k++;
    end
    check("abort_pop_seen", (pop_cyc.size() > n0) ? 1 : 0, 1);
    repeat (200) @(posedge clk_amisha);
    #1;
    reset_amisha = 1'b0;
    repeat (2) @(posedge clk_amisha);
    #1;
    reset_amisha = 1'b1;
    wait_idle(3000, "abort");
    check("abort_pops", pop_cyc.size() - n0, 2);

    // Data input wiggles mid-frame while the FIFO is empty.
    n0 = pop_cyc.size();
    push_word(8'h5A);
    k = 0;
    while (pop_cyc.size() == n0 && k < 100) begin
      @(negedge clk_amisha);
      k++;
    end
    for (int i = 0; i < 10; i++) begin
      repeat (50) @(posedge clk_amisha);
      #1;
      noise = 8'($urandom);
    end
    wait_idle(2000, "noise");

    // Parity-relevant words (odd and even number of ones).
    n0 = pop_cyc.size();
    push_word(8'h07);
    push_word(8'h03);
    wait_idle(4000, "parity");
    check("parity_pops", pop_cyc.size() - n0, 2);
    if (pop_cyc.size() - n0 == 2) check("parity_gap", pop_cyc[n0 + 1] - pop_cyc[n0], FRAME + 1);

    // Totals: one aborted frame produces a pop but no done tick.
    check("total_pops", pop_cyc.size(), 9);
    check("total_done", done_cnt, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
